// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC capture path: sink RAM geometry and the
// capture-writer state encoding.
package lpc_pkg;

  localparam int LPC_SAMPLE_W = 16;
  localparam int SINK_ADDR_W  = 13;
  localparam int SINK_DEPTH   = 8192;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } lpc_state_e;

endpackage

// File: rtl/lpc_sink_writer_if.sv
// Bundle of the Avalon-ST sample input and the sink RAM port-2 write bus.
// master = filter/RAM side (testbench), slave = lpc_sink_writer.
interface lpc_sink_writer_if
  import lpc_pkg::*;
#(
  parameter int DATA_W = LPC_SAMPLE_W,
  parameter int ADDR_W = SINK_ADDR_W
);

  // Avalon-ST sample stream
  logic [DATA_W-1:0]   in_data;
  logic                in_valid;
  logic                in_sop;
  logic                in_eop;
  logic                in_ready;

  // RAM port 2
  logic [ADDR_W-1:0]   ram_address;
  logic                ram_chipselect;
  logic                ram_write;
  logic [DATA_W-1:0]   ram_writedata;
  logic [DATA_W/8-1:0] ram_byteenable;

  modport master (
    output in_data, in_valid, in_sop, in_eop,
    input  in_ready,
    input  ram_address, ram_chipselect, ram_write, ram_writedata, ram_byteenable
  );

  modport slave (
    input  in_data, in_valid, in_sop, in_eop,
    output in_ready,
    output ram_address, ram_chipselect, ram_write, ram_writedata, ram_byteenable
  );

endinterface

// File: rtl/lpc_sink_writer.sv
// Capture writer: on start, hunts for a start-of-packet on the filter stream
// and writes a programmed number of samples into consecutive sink RAM words
// (wrapping at the top of the RAM), then pulses done.
//
// Handshake: a beat transfers at a rising edge where in_valid && in_ready.
// in_ready depends only on state and abort, never on in_valid, so the source
// may hold a beat for as long as it likes. abort drops in_ready in the same
// cycle, so no beat is taken on the cycle the capture is abandoned.
module lpc_sink_writer
  import lpc_pkg::*;
#(
  parameter int DATA_W = LPC_SAMPLE_W,
  parameter int ADDR_W = SINK_ADDR_W,
  parameter int DEPTH  = SINK_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W:0]   cfg_length,
  lpc_sink_writer_if.slave  bus,
  output logic              busy,
  output logic              done,
  output logic              short,
  output logic [ADDR_W:0]   count,
  output lpc_state_e        dbg_state
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_L   = CNT_W'(1);

  lpc_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               short_q, short_d;
  // Final sample has been taken; one more CAPTURE cycle with in_ready low
  // lets its write strobe go out before done is raised.
  logic               wrap_q, wrap_d;
  // Zero-length start: done pulse without ever leaving IDLE.
  logic               zero_done_q, zero_done_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  logic               in_ready_c;
  logic               accept;
  logic               do_write;
  logic [CNT_W-1:0]   count_nxt;
  logic [CNT_W-1:0]   len_clamp;

  // Next-state, capture bookkeeping and registered RAM write request
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    count_d     = count_q;
    short_d     = short_q;
    wrap_d      = wrap_q;
    zero_done_d = 1'b0;
    wr_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    do_write    = 1'b0;

    len_clamp   = (cfg_length > DEPTH_L) ? DEPTH_L : cfg_length;
    count_nxt   = count_q + ONE_L;
    in_ready_c  = ((state_q == ARMED) || ((state_q == CAPTURE) && !wrap_q)) && !abort;
    accept      = bus.in_valid && in_ready_c;

    case (state_q)
      IDLE, DONE: begin
        wrap_d = 1'b0;
        if (state_q == DONE) state_d = IDLE;
        if (start && !abort) begin
          count_d = '0;
          short_d = 1'b0;
          if (len_clamp == '0) begin
            zero_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            base_d  = cfg_base;
            len_d   = len_clamp;
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (accept && bus.in_sop) begin
          do_write = 1'b1;
          state_d  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (wrap_q) begin
          wrap_d  = 1'b0;
          state_d = DONE;
        end else if (accept) begin
          do_write = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_write) begin
      wr_d    = 1'b1;
      addr_d  = base_q + count_q[ADDR_W-1:0];
      wdata_d = bus.in_data;
      count_d = count_nxt;
      if ((count_nxt == len_q) || bus.in_eop) wrap_d = 1'b1;
      if (bus.in_eop && (count_nxt != len_q)) short_d = 1'b1;
    end

    if (abort) begin
      state_d = IDLE;
      wrap_d  = 1'b0;
    end
  end

  // State and datapath registers, asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      count_q     <= '0;
      short_q     <= 1'b0;
      wrap_q      <= 1'b0;
      zero_done_q <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      count_q     <= count_d;
      short_q     <= short_d;
      wrap_q      <= wrap_d;
      zero_done_q <= zero_done_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  // Output mapping; busy and done decode directly from registered state
  always_comb begin
    bus.in_ready       = in_ready_c;
    bus.ram_chipselect = wr_q;
    bus.ram_write      = wr_q;
    bus.ram_address    = addr_q;
    bus.ram_writedata  = wdata_q;
    bus.ram_byteenable = '1;
    busy               = (state_q == ARMED) || (state_q == CAPTURE);
    done               = (state_q == DONE) || zero_done_q;
    short              = short_q;
    count              = count_q;
    dbg_state          = state_q;
  end

endmodule

// File: tb/tb_lpc_sink_writer.sv
// Testbench for lpc_sink_writer: directed scenarios plus randomized captures
// checked against a list-based model of the capture rules.
module tb_lpc_sink_writer;
  import lpc_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 13;
  localparam int DEPTH = 8192;
  localparam int W     = AW + DW;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, abort;
  logic [AW-1:0] cfg_base;
  logic [AW:0]   cfg_length;
  logic          busy, done, short;
  logic [AW:0]   count;
  lpc_state_e    dbg_state;

  lpc_sink_writer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  lpc_sink_writer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_base(cfg_base), .cfg_length(cfg_length), .bus(bus),
    .busy(busy), .done(done), .short(short), .count(count), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  beat_t cur_beats[$];
  int exp_count, n_consume;
  bit exp_short;
  int cyc = 0, first_wr_cyc = 0, last_wr_cyc = 0, done_cyc = 0, done_cnt = 0;
  int cs_err = 0, be_err = 0;

  // Bus monitor: records every write strobe and done pulse
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      cyc++;
      if (bus.ram_chipselect !== bus.ram_write) cs_err++;
      if (bus.ram_byteenable !== 2'b11) be_err++;
      if (bus.ram_write === 1'b1) begin
        if (obs_q.size() == 0) first_wr_cyc = cyc;
        obs_q.push_back({bus.ram_address, bus.ram_writedata});
        last_wr_cyc = cyc;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Reference model: walk the beat list, skip until the first SOP, then take
  // samples until the clamped length is reached or an EOP ends the packet.
  function automatic void model(input int base, input int len_raw);
    int len, idx, i;
    bit started, stop;
    len = (len_raw > DEPTH) ? DEPTH : len_raw;
    exp_q.delete();
    idx = 0; i = 0; started = 0; stop = 0;
    exp_short = 0; n_consume = 0;
    while (i < cur_beats.size() && idx < len && !stop) begin
      n_consume = i + 1;
      if (cur_beats[i].sop) started = 1;
      if (started) begin
        exp_q.push_back({AW'((base + idx) % DEPTH), cur_beats[i].data});
        idx++;
        if (cur_beats[i].eop && idx < len) begin
          exp_short = 1;
          stop = 1;
        end
      end
      i++;
    end
    exp_count = idx;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_sb();
    obs_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_cmd(input int base, input int len);
    cfg_base   = AW'(base);
    cfg_length = (AW+1)'(len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_base   = AW'($urandom);
    cfg_length = (AW+1)'($urandom);
  endtask

  task automatic send_beats(input int n, input bit gaps);
    logic acc;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      bus.in_data  = cur_beats[i].data;
      bus.in_sop   = cur_beats[i].sop;
      bus.in_eop   = cur_beats[i].eop;
      bus.in_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 20 && acc !== 1'b1; t++) begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk); #1;
      end
      if (acc !== 1'b1) begin
        tests_run++; tests_failed++;
        $display("FAIL ready_timeout: beat %0d not accepted, in_ready=%b expected 1", i, acc);
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = (done === 1'b1);
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL %s done_timeout: done=%b expected 1 within 20 cycles", name, done);
    end
  endtask

  task automatic check_capture(input string name);
    int mism, bad;
    #1;
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL %s write_count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end else begin
      mism = 0; bad = 0;
      foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) begin
        if (mism == 0) bad = i;
        mism++;
      end
      if (mism != 0) begin
        tests_failed++;
        $display("FAIL %s write_data[%0d]: got addr/data %h expected %h (%0d bad)",
                 name, bad, obs_q[bad], exp_q[bad], mism);
      end
    end
    tests_run++;
    if (count !== (AW+1)'(exp_count)) begin
      tests_failed++;
      $display("FAIL %s count: got %0d expected %0d", name, count, exp_count);
    end
    tests_run++;
    if (short !== exp_short) begin
      tests_failed++;
      $display("FAIL %s short: got %b expected %b", name, short, exp_short);
    end
    tests_run++;
    if (done_cnt != 1 || done_cyc != last_wr_cyc + 1) begin
      tests_failed++;
      $display("FAIL %s done_timing: got %0d pulses at cycle %0d expected 1 at %0d",
               name, done_cnt, done_cyc, last_wr_cyc + 1);
    end
    tests_run++;
    if (dbg_state !== IDLE || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s end_state: got state %0d busy %b expected 0/0", name, dbg_state, busy);
    end
  endtask

  task automatic run_capture(input int base, input int len, input bit gaps, input string name);
    clear_sb();
    model(base, len);
    start_cmd(base, len);
    send_beats(n_consume, gaps);
    wait_done(name);
    repeat (2) @(posedge clk);
    check_capture(name);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [48:0] got;
    #12;
    got = {bus.in_ready, bus.ram_chipselect, bus.ram_write, bus.ram_address,
           bus.ram_writedata, busy, done, short, count};
    tests_run++;
    if (got !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0", got);
    end
    tests_run++;
    if (dbg_state !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    clear_sb();
    cur_beats.delete();
    cur_beats.push_back('{data: 16'h1111, sop: 1'b1, eop: 1'b0});
    cur_beats.push_back('{data: 16'h2222, sop: 1'b0, eop: 1'b0});
    cur_beats.push_back('{data: 16'h3333, sop: 1'b0, eop: 1'b0});
    cur_beats.push_back('{data: 16'h4444, sop: 1'b0, eop: 1'b0});
    model(0, 4);
    start_cmd(0, 4);
    // a second start while armed must not change the capture or pulse done
    start_cmd(100, 0);
    send_beats(n_consume, 1'b0);
    wait_done("basic");
    repeat (2) @(posedge clk);
    check_capture("basic");
    tests_run++;
    if (last_wr_cyc - first_wr_cyc != 3) begin
      tests_failed++;
      $display("FAIL basic_consecutive: got span %0d expected 3", last_wr_cyc - first_wr_cyc);
    end
  endtask

  task automatic test_wrap();
    cur_beats.delete();
    for (int i = 0; i < 4; i++)
      cur_beats.push_back('{data: 16'($urandom), sop: 1'(i == 0), eop: 1'b0});
    run_capture(8190, 4, 1'b0, "wrap");
  endtask

  task automatic test_sop_hunt();
    cur_beats.delete();
    cur_beats.push_back('{data: 16'h0BAD, sop: 1'b0, eop: 1'b0});
    cur_beats.push_back('{data: 16'h0BEE, sop: 1'b0, eop: 1'b1});
    cur_beats.push_back('{data: 16'hA5A5, sop: 1'b1, eop: 1'b0});
    cur_beats.push_back('{data: 16'h5A5A, sop: 1'b0, eop: 1'b0});
    run_capture(int'($urandom_range(0, DEPTH - 1)), 2, 1'b0, "sop_hunt");
  endtask

  task automatic test_short();
    cur_beats.delete();
    for (int i = 0; i < 10; i++)
      cur_beats.push_back('{data: 16'($urandom), sop: 1'(i == 0), eop: 1'(i == 2)});
    run_capture(int'($urandom_range(0, DEPTH - 1)), 10, 1'b1, "short");
  endtask

  task automatic test_abort();
    clear_sb();
    cur_beats.delete();
    for (int i = 0; i < 5; i++)
      cur_beats.push_back('{data: 16'($urandom), sop: 1'(i == 0), eop: 1'b0});
    model(300, 8);
    start_cmd(300, 8);
    send_beats(n_consume, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk); #1;
    tests_run++;
    if (bus.in_ready !== 1'b0 || dbg_state !== IDLE) begin
      tests_failed++;
      $display("FAIL abort_idle: got in_ready %b state %0d expected 0/%0d", bus.in_ready, dbg_state, IDLE);
    end
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (obs_q.size() != 5 || obs_q.size() != exp_q.size() || obs_q[4] !== exp_q[4]) begin
      tests_failed++;
      $display("FAIL abort_writes: got %0d writes expected 5", obs_q.size());
    end
    tests_run++;
    if (count !== 14'd5) begin
      tests_failed++;
      $display("FAIL abort_count: got %0d expected 5", count);
    end
    tests_run++;
    if (done_cnt != 0) begin
      tests_failed++;
      $display("FAIL abort_no_done: got %0d done pulses expected 0", done_cnt);
    end
  endtask

  task automatic test_zero_length();
    clear_sb();
    start_cmd(77, 0);
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1 || dbg_state !== IDLE || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_len_done: got done %b state %0d busy %b expected 1/0/0", done, dbg_state, busy);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_len_pulse: got done %b expected 0", done);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (obs_q.size() != 0 || count !== '0) begin
      tests_failed++;
      $display("FAIL zero_len_nowrite: got %0d writes count %0d expected 0/0", obs_q.size(), count);
    end
  endtask

  task automatic test_back_to_back();
    int base2;
    clear_sb();
    cur_beats.delete();
    for (int i = 0; i < 3; i++)
      cur_beats.push_back('{data: 16'($urandom), sop: 1'(i == 0), eop: 1'b0});
    model(500, 3);
    start_cmd(500, 3);
    send_beats(n_consume, 1'b0);
    wait_done("b2b_first");
    // start issued during the done cycle
    base2 = int'($urandom_range(0, DEPTH - 1));
    start_cmd(base2, 2);
    @(negedge clk); #1;
    tests_run++;
    if (dbg_state !== ARMED || cyc != last_wr_cyc + 2) begin
      tests_failed++;
      $display("FAIL b2b_armed: got state %0d at cycle %0d expected %0d at %0d",
               dbg_state, cyc, ARMED, last_wr_cyc + 2);
    end
    clear_sb();
    cur_beats.delete();
    for (int i = 0; i < 2; i++)
      cur_beats.push_back('{data: 16'($urandom), sop: 1'(i == 0), eop: 1'b0});
    model(base2, 2);
    @(posedge clk); #1;
    send_beats(n_consume, 1'b0);
    wait_done("b2b_second");
    repeat (2) @(posedge clk);
    check_capture("b2b_second");
  endtask

  task automatic test_async_reset();
    logic [48:0] got;
    clear_sb();
    cur_beats.delete();
    for (int i = 0; i < 4; i++)
      cur_beats.push_back('{data: 16'($urandom), sop: 1'(i == 0), eop: 1'b0});
    start_cmd(1000, 8);
    send_beats(3, 1'b0);
    bus.in_data  = cur_beats[3].data;
    bus.in_valid = 1'b1;
    #2;
    tests_run++;
    if (bus.ram_write !== 1'b1 || count !== 14'd3) begin
      tests_failed++;
      $display("FAIL areset_pre: got write %b count %0d expected 1/3", bus.ram_write, count);
    end
    reset_n = 1'b0;
    #1;
    got = {bus.in_ready, bus.ram_chipselect, bus.ram_write, bus.ram_address,
           bus.ram_writedata, busy, done, short, count};
    tests_run++;
    if (got !== '0) begin
      tests_failed++;
      $display("FAIL areset_outputs: got %h expected 0", got);
    end
    tests_run++;
    if (dbg_state !== IDLE) begin
      tests_failed++;
      $display("FAIL areset_state: got %0d expected %0d", dbg_state, IDLE);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clamp();
    cur_beats.delete();
    for (int i = 0; i < DEPTH; i++)
      cur_beats.push_back('{data: 16'($urandom), sop: 1'(i == 0), eop: 1'b0});
    run_capture(int'($urandom_range(0, DEPTH - 1)), 12000, 1'b0, "clamp");
  endtask

  task automatic test_random();
    int base, len, lead;
    for (int it = 0; it < 25; it++) begin
      base = int'($urandom_range(0, DEPTH - 1));
      len  = int'($urandom_range(1, 24));
      lead = int'($urandom_range(0, 3));
      cur_beats.delete();
      for (int i = 0; i < lead; i++)
        cur_beats.push_back('{data: 16'($urandom), sop: 1'b0, eop: 1'($urandom_range(0, 1))});
      for (int i = 0; i < len; i++)
        cur_beats.push_back('{data: 16'($urandom),
                              sop: 1'((i == 0) || ($urandom_range(0, 7) == 0)),
                              eop: 1'((i > 0) && ($urandom_range(0, 9) == 0))});
      run_capture(base, len, 1'b1, $sformatf("random%0d", it));
    end
  endtask

  task automatic test_bus_invariants();
    tests_run++;
    if (cs_err != 0) begin
      tests_failed++;
      $display("FAIL cs_eq_write: got %0d mismatching cycles expected 0", cs_err);
    end
    tests_run++;
    if (be_err != 0) begin
      tests_failed++;
      $display("FAIL byteenable: got %0d non-all-ones cycles expected 0", be_err);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    cfg_base     = '0;
    cfg_length   = '0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;

    test_reset();
    test_basic();
    test_wrap();
    test_sop_hunt();
    test_short();
    test_abort();
    test_zero_length();
    test_back_to_back();
    test_async_reset();
    test_clamp();
    test_random();
    test_bus_invariants();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lpc_sink_writer.md
# lpc_sink_writer

Capture stage between the LPC filter's Avalon-ST output and port 2 of the 8192×16 dual-port sink RAM. On a start command it waits for a start-of-packet, then writes a programmed number of 16-bit samples into consecutive RAM words from a base address. It reports completion and sample count to the Nios-side control logic, which reads the results through RAM port 1.

## Interface
Parameters:
- DATA_W, 16, sample width; equals RAM word width.
- ADDR_W, 13, RAM word-address width.
- DEPTH, 8192, RAM words; must equal 2**ADDR_W.

Ports:
- clk  in  1  single clock; the RAM port-2 clock is driven from the same net.
- reset_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle pulse; arms a capture.
- abort  in  1  one-cycle pulse; returns to IDLE.
- cfg_base  in  ADDR_W  first RAM word of the capture.
- cfg_length  in  ADDR_W+1  number of samples to capture.
- in_data  in  DATA_W  Avalon-ST sample.
- in_valid  in  1  sample valid.
- in_sop  in  1  start of packet.
- in_eop  in  1  end of packet.
- in_ready  out  1  sink ready.
- ram_address  out  ADDR_W  drives RAM address2.
- ram_chipselect  out  1  drives RAM chipselect2.
- ram_write  out  1  drives RAM write2.
- ram_writedata  out  DATA_W  drives RAM writedata2.
- ram_byteenable  out  DATA_W/8  drives RAM byteenable2; constant all-ones.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  one-cycle pulse at capture end.
- short  out  1  latched; capture ended on in_eop before cfg_length samples.
- count  out  ADDR_W+1  samples written in the last or current capture.

## Operation
- States and behaviour:
  - IDLE: in_ready=0.
    - start with cfg_length=0: done pulses next cycle, count=0, no RAM writes, state stays IDLE.
    - start with cfg_length≠0: latch base and length, clear count and short, go to ARMED.
  - ARMED: in_ready=1. Beats without in_sop are accepted and discarded. The first beat with in_valid & in_sop is written as sample 0, then state goes to CAPTURE.
  - CAPTURE: in_ready=1 and every valid beat is written.
    - in_sop mid-capture is ignored; the data is still written.
    - When the accepted beat makes count equal the latched length, go to DONE.
    - An in_eop beat before that point is written, sets short=1, and goes to DONE.
  - DONE: in_ready=0 for one cycle, done=1, then IDLE.
- Length clamp: cfg_length > DEPTH is treated as DEPTH.
- Address arithmetic: address = (base + index) mod DEPTH, ADDR_W-bit unsigned. A capture wraps from word DEPTH-1 to word 0.
- start while busy is ignored. The latched configuration is not affected by later cfg_* changes.
- abort in any state:
  - Goes to IDLE next cycle and drops in_ready.
  - A write already registered still completes.
  - No done pulse. count holds the number of samples written.
- If start and abort arrive in the same cycle, abort wins.

## Timing
- Reset values: in_ready=0, ram_chipselect=0, ram_write=0, ram_address=0, ram_writedata=0, busy=0, done=0, short=0, count=0. ram_byteenable is all-ones at all times. State is IDLE.
- RAM write latency: a beat accepted at edge N appears as ram_chipselect=ram_write=1 with its address and data for exactly one cycle after edge N. The write completes at edge N+1. No waitrequest exists, so one sample per cycle is sustained.
- ram_chipselect equals ram_write; both are low whenever no write is issued.
- count is incremented at the same edge that registers the write.
- done is asserted in the cycle after the last write strobe, which is the DONE state.
- Back-to-back captures: the earliest accepted start is at the edge where done=1, so ARMED begins 2 cycles after the last write.
- busy is combinational from state.

## Structure
- Shared package lpc_pkg holds:
  - the state enum: IDLE, ARMED, CAPTURE, DONE;
  - LPC_SAMPLE_W=16, SINK_ADDR_W=13, SINK_DEPTH=8192.
- Single module, no sub-modules. The address generator is a counter plus adder inline.

## Test plan
- base=0, length=4, ARMED, beats 0x1111/0x2222/0x3333/0x4444 with in_sop on the first beat. Expect:
  - writes to words 0..3 on consecutive cycles;
  - done one cycle after the last write, count=4, short=0.
- base=8190, length=4. Expect writes to words 8190, 8191, 0, 1, and count=4.
- Two non-SOP beats, then an SOP beat 0xA5A5, length=2. Expect:
  - the first two beats are dropped;
  - 0xA5A5 is written to word base.
- length=10, in_eop on the 3rd sample. Expect 3 writes, done pulse, short=1, count=3.
- length=8, abort after the 5th accepted beat. Expect:
  - 5 writes, no done;
  - in_ready=0 next cycle, count=5, state IDLE.
- Reset: assert reset_n=0 mid-capture, asynchronously. Expect all outputs at reset values immediately. Separately, start with cfg_length=0 gives done next cycle and no ram_write.
